// File: rtl/compress_pkg.sv
// Shared types for the word-match compressor: match codes, dictionary FSM states
// and the per-entry move-to-front select encoding.
package compress_pkg;

  localparam int unsigned DICT_ENTRY_DEF = 16;
  localparam int unsigned DICT_WORD_DEF  = 32;

  typedef enum logic [1:0] {
    MATCH_NONE = 2'b00,
    MATCH_2B   = 2'b01,
    MATCH_3B   = 2'b10,
    MATCH_FULL = 2'b11
  } match_e;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } dict_state_e;

  // Source of each entry's next value.
  typedef enum logic [1:0] {
    SEL_HOLD = 2'b00,
    SEL_PREV = 2'b01,
    SEL_NEW  = 2'b10,
    SEL_LOC  = 2'b11
  } sel_e;

  typedef struct packed {
    logic full_hit;
    logic part_hit;
    logic miss;
  } upd_kind_t;

  // A comparator hit only counts when it lands on a populated entry.
  function automatic upd_kind_t classify(input logic       accept,
                                         input logic [1:0] mtype,
                                         input logic       loc_valid);
    upd_kind_t k;
    k = '0;
    if (accept) begin
      if ((match_e'(mtype) != MATCH_NONE) && loc_valid) begin
        k.full_hit = (match_e'(mtype) == MATCH_FULL);
        k.part_hit = (match_e'(mtype) != MATCH_FULL);
      end else begin
        k.miss = 1'b1;
      end
    end
    return k;
  endfunction

endpackage

// File: rtl/mtf_dictionary_if.sv
// Update/observe bus of the move-to-front dictionary.
interface mtf_dictionary_if #(
  parameter int unsigned DICT_ENTRY = compress_pkg::DICT_ENTRY_DEF,
  parameter int unsigned DICT_WORD  = compress_pkg::DICT_WORD_DEF
);
  localparam int unsigned LOC_W = $clog2(DICT_ENTRY);

  logic                            i_flush;
  logic                            i_valid;
  logic                            o_ready;
  logic [DICT_WORD-1:0]            i_data;
  logic [1:0]                      i_type_matched;
  logic [LOC_W-1:0]                i_location;
  logic [DICT_ENTRY*DICT_WORD-1:0] o_dict;
  logic [DICT_ENTRY-1:0]           o_dict_valid;
  logic [LOC_W:0]                  o_valid_count;

  modport master (
    output i_flush, i_valid, i_data, i_type_matched, i_location,
    input  o_ready, o_dict, o_dict_valid, o_valid_count
  );

  modport slave (
    input  i_flush, i_valid, i_data, i_type_matched, i_location,
    output o_ready, o_dict, o_dict_valid, o_valid_count
  );

endinterface

// File: rtl/mtf_shift_ctrl.sv
// Per-entry next-value select for one move-to-front update.
module mtf_shift_ctrl import compress_pkg::*; #(
  parameter int unsigned DICT_ENTRY = DICT_ENTRY_DEF
) (
  input  upd_kind_t                       kind,
  input  logic [$clog2(DICT_ENTRY)-1:0]   location,
  output sel_e                            sel [DICT_ENTRY]
);

  localparam int unsigned LOC_W = $clog2(DICT_ENTRY);

  // Hits shift entries 0..L-1 down by one; a miss shifts the whole array.
  always_comb begin
    for (int k = 0; k < int'(DICT_ENTRY); k++) begin
      sel[k] = SEL_HOLD;
      if (kind.miss) begin
        sel[k] = (k == 0) ? SEL_NEW : SEL_PREV;
      end else if (kind.full_hit || kind.part_hit) begin
        if (k == 0) begin
          sel[k] = kind.full_hit ? SEL_LOC : SEL_NEW;
        end else if (LOC_W'(k) <= location) begin
          sel[k] = SEL_PREV;
        end
      end
    end
  end

endmodule

// File: rtl/mtf_dictionary.sv
// Move-to-front dictionary: holds the entry registers, valid mask, occupancy
// count and the RUN/FLUSH control; ordering decisions come from mtf_shift_ctrl.
module mtf_dictionary import compress_pkg::*; #(
  parameter int unsigned DICT_ENTRY = DICT_ENTRY_DEF,
  parameter int unsigned DICT_WORD  = DICT_WORD_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  mtf_dictionary_if.slave  bus
);

  localparam int unsigned       LOC_W    = $clog2(DICT_ENTRY);
  localparam int unsigned       CNT_W    = LOC_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DICT_ENTRY);

  dict_state_e state_q, state_d;
  logic        ready;
  logic        accept;

  logic [DICT_ENTRY-1:0][DICT_WORD-1:0] dict_q, dict_d, dict_shift;
  logic [DICT_ENTRY-1:0]                mask_q, mask_d;
  logic [CNT_W-1:0]                     count_q, count_d;

  upd_kind_t kind;
  sel_e      sel [DICT_ENTRY];

  // Control FSM: a flush request blocks the word offered in the same cycle.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      RUN: begin
        ready = ~bus.i_flush;
        if (bus.i_flush) begin
          state_d = FLUSH;
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign accept = bus.i_valid & ready;
  assign kind   = classify(accept, bus.i_type_matched, mask_q[bus.i_location]);

  mtf_shift_ctrl #(
    .DICT_ENTRY (DICT_ENTRY)
  ) u_shift_ctrl (
    .kind     (kind),
    .location (bus.i_location),
    .sel      (sel)
  );

  assign dict_shift = {dict_q[DICT_ENTRY-2:0], DICT_WORD'(0)};

  // Next dictionary contents; FLUSH wipes everything on its closing edge.
  always_comb begin
    dict_d  = dict_q;
    mask_d  = mask_q;
    count_d = count_q;
    if (state_q == FLUSH) begin
      dict_d  = '0;
      mask_d  = '0;
      count_d = '0;
    end else begin
      for (int k = 0; k < int'(DICT_ENTRY); k++) begin
        case (sel[k])
          SEL_PREV: dict_d[k] = dict_shift[k];
          SEL_NEW:  dict_d[k] = bus.i_data;
          SEL_LOC:  dict_d[k] = dict_q[bus.i_location];
          default:  dict_d[k] = dict_q[k];
        endcase
      end
      if (kind.miss) begin
        mask_d  = {mask_q[DICT_ENTRY-2:0], 1'b1};
        count_d = (count_q == CNT_FULL) ? count_q : count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dict_q  <= '0;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      dict_q  <= dict_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  assign bus.o_ready       = ready;
  assign bus.o_dict        = dict_q;
  assign bus.o_dict_valid  = mask_q;
  assign bus.o_valid_count = count_q;

endmodule
